// File: rtl/ex_mdu_if.sv
// Handshake/result bundle between the EX stage and the iterative multiply/divide unit.
interface ex_mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        flush;
  logic        busy;
  logic        stall_o;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start, op, a, b, rd_hilo, flush,
    input  busy, stall_o, done, hi_o, lo_o
  );

  modport slave (
    input  start, op, a, b, rd_hilo, flush,
    output busy, stall_o, done, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative 32x32 multiply / restoring divide unit holding architectural HI/LO.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise divides are no-ops.
module ex_mdu (
  input  logic    clk,
  input  logic    rst,
  ex_mdu_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] mcand_q;
  logic        neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        signedOp;
  logic [31:0] magA;
  logic [31:0] magB;
  logic        accept;
  logic [32:0] mulSum;
  logic [63:0] mulAcc_d;
  logic [63:0] mulRes;

  assign signedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign magA     = (signedOp && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign magB     = (signedOp && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
  assign accept   = bus.start && !bus.stall_o && !bus.flush;

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  assign mulSum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'd0)};
  assign mulAcc_d = {mulSum, acc_q[31:1]};
  assign mulRes   = neg_q ? (64'd0 - acc_q) : acc_q;

`ifdef MDU_DIV_EN
  logic        isDiv_q;
  logic        negR_q;
  logic [32:0] rem_q;
  logic [33:0] trial;
  logic [33:0] diff;
  logic        ge;
  logic [32:0] rem_d;
  logic [63:0] divAcc_d;
  logic [31:0] divLo;
  logic [31:0] divHi;

  // Restoring step: dividend bits shift out of acc_q[31] while quotient bits shift in.
  assign trial    = {rem_q, acc_q[31]};
  assign diff     = trial - {2'b00, mcand_q};
  assign ge       = ~diff[33];
  assign rem_d    = ge ? diff[32:0] : trial[32:0];
  assign divAcc_d = {acc_q[63:32], acc_q[30:0], ge};
  assign divLo    = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign divHi    = negR_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      mcand_q <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      isDiv_q <= 1'b0;
      negR_q  <= 1'b0;
      rem_q   <= 33'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              OP_MULT, OP_MULTU: begin
                state_q <= RUN;
                cnt_q   <= 5'd0;
                acc_q   <= {32'd0, magB};
                mcand_q <= magA;
                neg_q   <= signedOp & (bus.a[31] ^ bus.b[31]);
`ifdef MDU_DIV_EN
                isDiv_q <= 1'b0;
                negR_q  <= 1'b0;
`endif
              end
`ifdef MDU_DIV_EN
              OP_DIV, OP_DIVU: begin
                state_q <= RUN;
                cnt_q   <= 5'd0;
                acc_q   <= {32'd0, magA};
                mcand_q <= magB;
                rem_q   <= 33'd0;
                isDiv_q <= 1'b1;
                // A zero divisor yields an all-ones quotient and |a| remainder; restoring
                // the dividend's sign on HI alone reproduces the raw operand.
                neg_q   <= signedOp & (bus.a[31] ^ bus.b[31]) & (bus.b != 32'd0);
                negR_q  <= signedOp & bus.a[31];
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
`ifdef MDU_DIV_EN
            acc_q <= isDiv_q ? divAcc_d : mulAcc_d;
            if (isDiv_q) rem_q <= rem_d;
`else
            acc_q <= mulAcc_d;
`endif
            if (cnt_q == 5'd31) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!bus.flush) begin
            done_q <= 1'b1;
`ifdef MDU_DIV_EN
            if (isDiv_q) begin
              hi_q <= divHi;
              lo_q <= divLo;
            end else begin
              hi_q <= mulRes[63:32];
              lo_q <= mulRes[31:0];
            end
`else
            hi_q <= mulRes[63:32];
            lo_q <= mulRes[31:0];
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.stall_o = bus.busy & (bus.start | bus.rd_hilo);
  assign bus.done    = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus pushes expected {HI,LO}, a monitor pops on done.
// Honours MDU_DIV_EN the same way as the design build.
module tb_ex_mdu;

  logic clk;
  logic rst;
  ex_mdu_if bus ();

  ex_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;
  logic [63:0] expQ[$];
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference semantics straight from the arithmetic definition of each opcode.
  function automatic logic [63:0] refMdu(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin p = ua * ub; return p; end
      3'd2, 3'd3: begin
        if (!DIV_EN) return cur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd2) begin
          sq = sa / sb; sr = sa % sb; q = sq; r = sr;
        end else begin
          q = ua / ub; r = ua % ub;
        end
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  function automatic bit isIterative(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (DIV_EN && (op == 3'd2 || op == 3'd3));
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCnt++;
        $display("[TB] FAIL unexpectedDone: got done=1, expected done=0");
      end else begin
        checkOutput("result", {bus.hi_o, bus.lo_o}, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int flushAt, input bit probeStall);
    int busyCnt;
    int doneAt;
    logic [63:0] expv;
    busyCnt = 0;
    doneAt  = -1;
    expv    = refMdu(op, a, b, {modelHi, modelLo});
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (!isIterative(op)) begin
      {modelHi, modelLo} = expv;
      @(negedge clk);
      checkOutput("idleBusy", {63'd0, bus.busy}, 64'd0);
      checkOutput("idleHiLo", {bus.hi_o, bus.lo_o}, {modelHi, modelLo});
    end else begin
      if (flushAt < 0) begin
        expQ.push_back(expv);
        {modelHi, modelLo} = expv;
      end
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (probeStall && i == 5) bus.rd_hilo = 1'b1;
        if (i == flushAt) bus.flush = 1'b1;
        #1;
        if (bus.busy) busyCnt++;
        if (probeStall && i >= 5)
          checkOutput($sformatf("stall@%0d", i), {63'd0, bus.stall_o}, {63'd0, i <= 33});
        if (flushAt > 0 && i == flushAt + 1) begin
          bus.flush = 1'b0;
          checkOutput("flushBusy", {63'd0, bus.busy}, 64'd0);
          checkOutput("flushHiLo", {bus.hi_o, bus.lo_o}, {modelHi, modelLo});
        end
        if (bus.done) begin
          doneAt = i;
          if (flushAt < 0) break;
        end
      end
      bus.rd_hilo = 1'b0;
      if (flushAt < 0) begin
        checkOutput("latency", 64'(doneAt), 64'd34);
        checkOutput("busyCycles", 64'(busyCnt), 64'd33);
      end else begin
        checkOutput("flushNoDone", 64'(doneAt), 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.rd_hilo = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetHiLo", {bus.hi_o, bus.lo_o}, 64'd0);
    checkOutput("resetBusyDone", {62'd0, bus.busy, bus.done}, 64'd0);

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7, -1, 1'b1);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    applyStimulus(3'd3, 32'd7, 32'd0, -1, 1'b0);
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd0, -1, 1'b0);
    applyStimulus(3'd2, 32'd8, 32'd2, -1, 1'b0);
    applyStimulus(3'd5, 32'h0000_1234, 32'd0, -1, 1'b0);
    applyStimulus(3'd0, 32'd3, 32'd4, -1, 1'b0);
    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd1, -1, 1'b0);

    applyStimulus(3'd4, 32'hA5A5_A5A5, 32'd0, -1, 1'b0);
    applyStimulus(3'd5, 32'hA5A5_A5A5, 32'd0, -1, 1'b0);
    applyStimulus(3'd0, 32'd12345, 32'd678, 10, 1'b0);

    // An issue coinciding with flush must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0BAD_0BAD; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flushStartHiLo", {bus.hi_o, bus.lo_o}, {modelHi, modelLo});

    // Reset in the middle of a multiply clears everything.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd99; bus.b = 32'd77;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midRunBusy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    modelHi = 32'd0; modelLo = 32'd0;
    checkOutput("midRstHiLo", {bus.hi_o, bus.lo_o}, 64'd0);
    checkOutput("midRstBusyDone", {62'd0, bus.busy, bus.done}, 64'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      applyStimulus(rop, ra, rb, -1, 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the ID/EX rs/rt operands and a decoded MDU opcode, computes 64-bit products or quotient/remainder pairs over multiple cycles, and holds the results in architectural HI/LO registers. While it is busy, it raises a stall request to the hazard logic whenever EX tries to issue another MDU op or read HI/LO.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle issue strobe from EX; qualified by `!stall_o`.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, treated as no-op.
- a  in  32  rs operand (ID/EX rs_ex_o after forwarding).
- b  in  32  rt operand (ID/EX rt_ex_o after forwarding).
- rd_hilo  in  1  EX holds MFHI/MFLO this cycle.
- flush  in  1  abort any in-flight operation.
- busy  out  1  high while an iterative op is in flight.
- stall_o  out  1  combinational; equals `busy & (start | rd_hilo)`.
- done  out  1  one-cycle pulse after HI/LO are written by MULT/DIV.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.

## Operation
- **States:**
  - IDLE
  - RUN: counter `cnt` 0..31.
  - FIX: sign correction and HI/LO write.
- **IDLE, `start` with MTHI/MTLO:** HI or LO takes `a` at that edge. No busy, no done.
- **IDLE, `start` with MULT/DIV ops:**
  - Latch the operand magnitudes. Signed ops take the absolute value; `0x80000000` stays `0x80000000` as unsigned.
  - Latch `neg_q = a[31]^b[31]` and `neg_r = a[31]`; both are forced to 0 for unsigned ops.
  - Go to RUN with `cnt=0`.
- **RUN, multiply:** radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- **RUN, divide:** restoring division, one quotient bit per cycle, 33-bit partial remainder.
- **Leaving RUN:** after `cnt==31`, go to FIX.
- **FIX:**
  - MULT: negate the 64-bit product if `neg_q`, then `{HI,LO}=product`.
  - DIV: `LO = neg_q ? -q : q` and `HI = neg_r ? -r : r`.
  - Next state is IDLE, with `done=1` for the following cycle.
- **Divide by zero (`b==0`):**
  - LO=0xFFFFFFFF, HI=`a` (the raw operand).
  - No sign correction is applied.
  - Full latency still applies.
- **Signed overflow (`0x80000000 / 0xFFFFFFFF`):** LO=0x80000000, HI=0.
- **`start` while busy:** ignored. Upstream sees `stall_o=1` and holds the instruction.
- **`flush` in RUN or FIX:** return to IDLE at the next edge. HI/LO are unchanged, and `done` is not pulsed. `flush` has priority over FIX completion.
- **`flush` with `start` in IDLE:** the op is not accepted.
- **Reset:** state IDLE, `cnt=0`, HI=LO=0, `busy=0`, `done=0`.

## Timing
- **Issue:** at edge E0, `start` is sampled.
- **Busy window:** `busy` is high from after E0 until after E33, i.e. 33 cycles (32 RUN + 1 FIX).
- **Results:** HI/LO are written at edge E33.
- **Done:** `done` is high in the cycle after E33, together with the new `hi_o`/`lo_o`.
- **Back-to-back:** a new op may issue in the `done` cycle.
- **MTHI/MTLO:** 1-cycle latency; the value is visible after E0.
- **MFHI/MFLO after MTHI:** an MFHI in the next cycle sees the new value.
- **`stall_o`:** purely combinational from `busy`, `start` and `rd_hilo`; no registered delay.

## Configuration
- **Macro:** `MDU_DIV_EN`.
- **Defined:** DIV/DIVU are implemented as above.
- **Undefined:**
  - Divider datapath and 33-bit remainder logic are compiled out.
  - DIV/DIVU `start` is treated as a no-op: no busy, no done, HI/LO unchanged.
  - MULT/MULTU/MTHI/MTLO are unaffected.

## Test plan
- MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` -> `done` 34 cycles after `start`; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly 33 cycles.
- MULT `a=0xFFFFFFFD` (-3), `b=7` -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV `a=0xFFFFFFF9` (-7), `b=2` -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU `7/0` -> LO=0xFFFFFFFF, HI=0x00000007.
- MULT issued, then `rd_hilo=1` at cycle 5 -> `stall_o=1` until `busy` drops; MTLO `0x1234` in IDLE -> LO=0x1234 next cycle, no `busy`.
- `flush` at RUN cycle 10 of a MULT with HI=LO=0xA5A5A5A5 preloaded -> IDLE next edge, HI/LO unchanged, no `done`; `rst` mid-RUN -> all outputs zero next edge.
- Build without `MDU_DIV_EN`: DIV `8/2` -> `busy` stays 0, no `done`, HI/LO unchanged; MULT `3*4` -> LO=12.
